// File: rtl/dino_pkg.sv
// Shared constants, type codes and obstacle hitbox table for the dino game judge.
package dino_pkg;

  localparam int DINO_X    = 40;
  localparam int DINO_W    = 20;
  localparam int DINO_H    = 22;
  localparam int GROUND_Y  = 200;
  localparam int GB        = GROUND_Y + DINO_H;
  localparam int SCORE_DIV = 4;
  localparam int DIV_W     = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

  typedef enum logic [2:0] {
    LOW_BIRD     = 3'd0,
    HIGH_BIRD    = 3'd1,
    SMALL_CACTUS = 3'd2,
    MANY_CACTUS  = 3'd3,
    BIG_CACTUS   = 3'd4,
    NOTHING      = 3'd5
  } obj_type_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } game_state_t;

  // Vertical extents are stored as distances above the ground line GB.
  typedef struct packed {
    logic       valid;
    logic [9:0] w;
    logic [9:0] top_off;
    logic [9:0] bot_off;
  } hitbox_t;

  function automatic hitbox_t hitbox_of(input logic [2:0] t);
    hitbox_t hb;
    hb = '0;
    case (obj_type_t'(t))
      SMALL_CACTUS: hb = '{valid: 1'b1, w: 10'd10, top_off: 10'd20, bot_off: 10'd0};
      MANY_CACTUS:  hb = '{valid: 1'b1, w: 10'd26, top_off: 10'd20, bot_off: 10'd0};
      BIG_CACTUS:   hb = '{valid: 1'b1, w: 10'd14, top_off: 10'd30, bot_off: 10'd0};
      LOW_BIRD:     hb = '{valid: 1'b1, w: 10'd20, top_off: 10'd30, bot_off: 10'd14};
      HIGH_BIRD:    hb = '{valid: 1'b1, w: 10'd20, top_off: 10'd50, bot_off: 10'd34};
      default:      hb = '0;
    endcase
    return hb;
  endfunction

endpackage

// File: rtl/dino_box_overlap.sv
// Combinational test of the dino hitbox against one obstacle slot.
module dino_box_overlap
  import dino_pkg::*;
(
  input  logic [8:0] dino_pos,
  input  logic [8:0] pos,
  input  logic [2:0] obj_type,
  input  logic       en,
  output logic       hit
);

  hitbox_t    hb;
  logic [9:0] dino_top, dino_bot, obj_l, obj_r, box_top, box_bot;
  logic       x_ovl, y_ovl;

  // 10-bit sums so a low dino or a right-edge obstacle cannot wrap.
  assign hb       = hitbox_of(obj_type);
  assign dino_top = {1'b0, dino_pos};
  assign dino_bot = dino_top + 10'(DINO_H);
  assign obj_l    = {1'b0, pos};
  assign obj_r    = obj_l + hb.w;
  assign box_top  = 10'(GB) - hb.top_off;
  assign box_bot  = 10'(GB) - hb.bot_off;

  assign x_ovl = (obj_l < 10'(DINO_X + DINO_W)) && (obj_r > 10'(DINO_X));
  assign y_ovl = (dino_top < box_bot) && (dino_bot > box_top);
  assign hit   = en && hb.valid && x_ovl && y_ovl;

endmodule

// File: rtl/dino_hit_judge.sv
// Game FSM, round-robin collision scan and BCD score for the dino game.
// Define DINO_HIGH_SCORE_EN to keep a high score across restarts.
module dino_hit_judge
  import dino_pkg::*;
(
  input  logic        game_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  dino_pos,
  input  logic [8:0]  danger_pos1,
  input  logic [8:0]  danger_pos2,
  input  logic [8:0]  danger_pos3,
  input  logic [2:0]  danger_type1,
  input  logic [2:0]  danger_type2,
  input  logic [2:0]  danger_type3,
  input  logic        danger_en1,
  input  logic        danger_en2,
  input  logic        danger_en3,
  output logic        run_en,
  output logic        game_over,
  output logic [1:0]  game_state,
  output logic [1:0]  hit_slot,
  output logic [15:0] score,
  output logic [15:0] high_score
);

  game_state_t      state, next_state;
  logic [1:0]       scan_idx;
  logic [DIV_W-1:0] div_cnt;
  logic [8:0]       sel_pos;
  logic [2:0]       sel_type;
  logic             sel_en;
  logic             slot_hit;
  logic             start_run;
  logic [15:0]      score_inc;
  logic             inc_carry;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_pos  = danger_pos1;
    sel_type = danger_type1;
    sel_en   = danger_en1;
    case (scan_idx)
      2'd1: begin
        sel_pos  = danger_pos2;
        sel_type = danger_type2;
        sel_en   = danger_en2;
      end
      2'd2: begin
        sel_pos  = danger_pos3;
        sel_type = danger_type3;
        sel_en   = danger_en3;
      end
      default: ;
    endcase
  end

  dino_box_overlap u_overlap (
    .dino_pos (dino_pos),
    .pos      (sel_pos),
    .obj_type (sel_type),
    .en       (sel_en),
    .hit      (slot_hit)
  );

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start)    next_state = ST_RUN;
      ST_RUN:  if (slot_hit) next_state = ST_OVER;
      ST_OVER: if (start)    next_state = ST_RUN;
      default:               next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    run_en     = (state == ST_RUN);
    game_over  = (state == ST_OVER);
    game_state = state;
  end

  assign start_run = start && (state != ST_RUN);

  // Ripple BCD increment, held at 9999.
  always_comb begin
    score_inc = score;
    inc_carry = (score != 16'h9999);
    for (int d = 0; d < 4; d++) begin
      if (inc_carry) begin
        if (score[d*4 +: 4] == 4'd9) begin
          score_inc[d*4 +: 4] = 4'd0;
        end else begin
          score_inc[d*4 +: 4] = score[d*4 +: 4] + 4'd1;
          inc_carry           = 1'b0;
        end
      end
    end
  end

  // A hit freezes scan, divider and score on the edge that enters OVER.
  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      scan_idx <= 2'd0;
      div_cnt  <= '0;
      score    <= 16'h0000;
      hit_slot <= 2'd3;
    end else if (start_run) begin
      scan_idx <= 2'd0;
      div_cnt  <= '0;
      score    <= 16'h0000;
      hit_slot <= 2'd3;
    end else if (state == ST_RUN) begin
      if (slot_hit) begin
        hit_slot <= scan_idx;
      end else begin
        scan_idx <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
        if (div_cnt == DIV_W'(SCORE_DIV - 1)) begin
          div_cnt <= '0;
          score   <= score_inc;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

`ifdef DINO_HIGH_SCORE_EN
  logic [15:0] high_q;

  // BCD codes order the same as their decimal values, so a plain compare works.
  always_ff @(posedge game_clk or posedge rst) begin
    if (rst)                                                  high_q <= 16'h0000;
    else if ((state == ST_RUN) && slot_hit && (score > high_q)) high_q <= score;
  end

  assign high_score = high_q;
`else
  assign high_score = 16'h0000;
`endif

endmodule

// File: tb/tb_dino_hit_judge.sv
// Self-checking bench for dino_hit_judge: integer-level game model plus directed scenarios.
module tb_dino_hit_judge;

  localparam int SCORE_DIV = 4;

  logic        game_clk;
  logic        rst;
  logic        start;
  logic [8:0]  dino_pos;
  logic [8:0]  danger_pos1, danger_pos2, danger_pos3;
  logic [2:0]  danger_type1, danger_type2, danger_type3;
  logic        danger_en1, danger_en2, danger_en3;
  logic        run_en, game_over;
  logic [1:0]  game_state, hit_slot;
  logic [15:0] score, high_score;

  int n_checks = 0;
  int n_pass   = 0;

  dino_hit_judge dut (
    .game_clk     (game_clk),
    .rst          (rst),
    .start        (start),
    .dino_pos     (dino_pos),
    .danger_pos1  (danger_pos1),
    .danger_pos2  (danger_pos2),
    .danger_pos3  (danger_pos3),
    .danger_type1 (danger_type1),
    .danger_type2 (danger_type2),
    .danger_type3 (danger_type3),
    .danger_en1   (danger_en1),
    .danger_en2   (danger_en2),
    .danger_en3   (danger_en3),
    .run_en       (run_en),
    .game_over    (game_over),
    .game_state   (game_state),
    .hit_slot     (hit_slot),
    .score        (score),
    .high_score   (high_score)
  );

  initial game_clk = 1'b0;
  always #5 game_clk = ~game_clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Game model: absolute hitbox rectangles, integer score.
  int m_state    = 0;
  int m_scan     = 0;
  int m_div      = 0;
  int m_score    = 0;
  int m_hit_slot = 3;
  int m_high     = 0;

  function automatic bit model_hit(int dino, int pos, int typ, bit en);
    int w, top, bot;
    if (!en) return 1'b0;
    case (typ)
      0: begin w = 20; top = 192; bot = 208; end
      1: begin w = 20; top = 172; bot = 188; end
      2: begin w = 10; top = 202; bot = 222; end
      3: begin w = 26; top = 202; bot = 222; end
      4: begin w = 14; top = 192; bot = 222; end
      default: return 1'b0;
    endcase
    return (pos < 60) && (pos + w > 40) && (dino < bot) && (dino + 22 > top);
  endfunction

  function automatic bit slot_hit(int idx);
    case (idx)
      0:       return model_hit(int'(dino_pos), int'(danger_pos1), int'(danger_type1), danger_en1);
      1:       return model_hit(int'(dino_pos), int'(danger_pos2), int'(danger_type2), danger_en2);
      default: return model_hit(int'(dino_pos), int'(danger_pos3), int'(danger_type3), danger_en3);
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge game_clk or posedge rst) begin
    if (rst) begin
      m_state <= 0; m_scan <= 0; m_div <= 0; m_score <= 0; m_hit_slot <= 3; m_high <= 0;
    end else if (m_state != 1) begin
      if (start) begin
        m_state <= 1; m_scan <= 0; m_div <= 0; m_score <= 0; m_hit_slot <= 3;
      end
    end else if (slot_hit(m_scan)) begin
      m_state    <= 2;
      m_hit_slot <= m_scan;
`ifdef DINO_HIGH_SCORE_EN
      if (m_score > m_high) m_high <= m_score;
`endif
    end else begin
      m_scan <= (m_scan + 1) % 3;
      m_div  <= (m_div + 1) % SCORE_DIV;
      if (m_div == SCORE_DIV - 1 && m_score < 9999) m_score <= m_score + 1;
    end
  end

  always @(posedge game_clk) begin
    #1;
    check("cyc_state",     16'(game_state), 16'(m_state));
    check("cyc_run_en",    16'(run_en),     16'(m_state == 1));
    check("cyc_game_over", 16'(game_over),  16'(m_state == 2));
    check("cyc_hit_slot",  16'(hit_slot),   16'(m_hit_slot));
    check("cyc_score",     score,           to_bcd(m_score));
    check("cyc_high",      high_score,      to_bcd(m_high));
  end

  task automatic set_slot(input int idx, input logic en, input logic [2:0] typ, input logic [8:0] pos);
    case (idx)
      1: begin danger_en1 = en; danger_type1 = typ; danger_pos1 = pos; end
      2: begin danger_en2 = en; danger_type2 = typ; danger_pos2 = pos; end
      default: begin danger_en3 = en; danger_type3 = typ; danger_pos3 = pos; end
    endcase
  endtask

  // Called on a falling edge; returns on the falling edge after the start edge.
  task automatic press_start();
    start = 1'b1;
    @(negedge game_clk);
    start = 1'b0;
  endtask

  task automatic wait_over(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge game_clk);
      #1;
      if (game_over) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 16'(seen), 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dino_pos = 9'd200;
    set_slot(1, 1'b0, 3'd5, 9'd0);
    set_slot(2, 1'b0, 3'd5, 9'd0);
    set_slot(3, 1'b0, 3'd5, 9'd0);
    #2;
    check("rst_state",    16'(game_state), 16'd0);
    check("rst_run_en",   16'(run_en),     16'd0);
    check("rst_over",     16'(game_over),  16'd0);
    check("rst_hit_slot", 16'(hit_slot),   16'd3);
    check("rst_score",    score,           16'h0000);
    check("rst_high",     high_score,      16'h0000);
    repeat (2) @(negedge game_clk);
    rst = 1'b0;

    // Standing dino against a ground cactus in slot 1.
    @(negedge game_clk);
    set_slot(1, 1'b1, 3'd2, 9'd50);
    press_start();
    wait_over(4, "t1_cactus_latency");
    check("t1_state",    16'(game_state), 16'd2);
    check("t1_hit_slot", 16'(hit_slot),   16'd0);
    check("t1_run_en",   16'(run_en),     16'd0);
    repeat (8) @(negedge game_clk);
    check("t1_score_frozen", score, 16'h0000);

    // Jumping dino clears a cactus in slot 2.
    dino_pos = 9'd150;
    set_slot(1, 1'b0, 3'd5, 9'd0);
    set_slot(2, 1'b1, 3'd2, 9'd45);
    press_start();
    repeat (20) @(negedge game_clk);
    check("t2_jump_no_hit", 16'(game_state), 16'd1);

    // Bird heights against a standing dino, slot 3.
    dino_pos = 9'd200;
    set_slot(2, 1'b0, 3'd5, 9'd0);
    set_slot(3, 1'b1, 3'd1, 9'd40);
    repeat (6) @(negedge game_clk);
    check("t3_high_bird_no_hit", 16'(game_state), 16'd1);
    set_slot(3, 1'b1, 3'd0, 9'd40);
    wait_over(3, "t3_low_bird_latency");
    check("t3_hit_slot", 16'(hit_slot), 16'd2);

    // Guarded slots and the x edge.
    @(negedge game_clk);
    set_slot(3, 1'b0, 3'd5, 9'd0);
    set_slot(1, 1'b1, 3'd5, 9'd40);
    press_start();
    repeat (6) @(negedge game_clk);
    check("t4_nothing_no_hit", 16'(game_state), 16'd1);
    set_slot(1, 1'b0, 3'd2, 9'd40);
    repeat (6) @(negedge game_clk);
    check("t4_disabled_no_hit", 16'(game_state), 16'd1);
    set_slot(1, 1'b1, 3'd2, 9'd60);
    repeat (6) @(negedge game_clk);
    check("t4_x_edge_no_hit", 16'(game_state), 16'd1);
    set_slot(1, 1'b1, 3'd2, 9'd59);
    wait_over(3, "t4_x_edge_hit");
    check("t4_hit_slot", 16'(hit_slot), 16'd0);

    // Score: 40 RUN ticks give 10 points; a start in RUN is ignored.
    @(negedge game_clk);
    set_slot(1, 1'b0, 3'd5, 9'd0);
    press_start();
    repeat (20) @(negedge game_clk);
    start = 1'b1;
    @(negedge game_clk);
    start = 1'b0;
    repeat (19) @(negedge game_clk);
    check("t5_score_40", score, 16'h0010);
    check("t5_start_ignored", 16'(game_state), 16'd1);

    // Reach 25, crash, then restart.
    repeat (60) @(negedge game_clk);
    check("t6_score_25", score, 16'h0025);
    set_slot(1, 1'b1, 3'd2, 9'd50);
    wait_over(3, "t6_hit_latency");
    check("t6_over_score", score, 16'h0025);
    check("t6_hit_slot", 16'(hit_slot), 16'd0);
    @(negedge game_clk);
    set_slot(1, 1'b0, 3'd5, 9'd0);
    press_start();
    check("t6_restart_score", score, 16'h0000);
    check("t6_restart_slot",  16'(hit_slot), 16'd3);
    check("t6_restart_state", 16'(game_state), 16'd1);
`ifdef DINO_HIGH_SCORE_EN
    check("t6_high_kept", high_score, 16'h0025);
`else
    check("t6_high_tied", high_score, 16'h0000);
`endif

    // Asynchronous reset in the middle of a run.
    repeat (10) @(negedge game_clk);
    rst = 1'b1;
    #1;
    check("t7_rst_state",    16'(game_state), 16'd0);
    check("t7_rst_run_en",   16'(run_en),     16'd0);
    check("t7_rst_over",     16'(game_over),  16'd0);
    check("t7_rst_hit_slot", 16'(hit_slot),   16'd3);
    check("t7_rst_score",    score,           16'h0000);
    check("t7_rst_high",     high_score,      16'h0000);
    @(negedge game_clk);
    rst = 1'b0;
    repeat (2) @(negedge game_clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
